mvm_row_accum: RTL and testbench

- Consumer side of the dot8 result stream in the MVM engine.
- A matrix row longer than 8 elements is split into NUM_CHUNKS 8-lane chunks. dot8 returns one partial dot product per chunk on result/ovalid.
- This block sums the partials of each row, buffers completed row sums in a small FIFO, and presents them on a valid/ready output toward the output vector memory writer.
- Drives busy/done back to the engine controller.

---
 rtl/mvm_row_accum.sv | 175 +++++++++++++++++
 tb/tb_mvm_row_accum.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_row_accum.sv
// mvm_row_accum
// Sums the per-chunk partial dot products coming from dot8 into one row sum
// per matrix row. Completed row sums go into a small first-word-fall-through
// FIFO, which drives a valid/ready stream toward the output vector writer.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               job start pulse (honoured only in IDLE)
//   num_chunks          chunks per row, sampled on an accepted start
//   num_rows            rows per job, sampled on an accepted start
//   in_result/in_valid  signed partial sums from dot8 (no backpressure)
//   out_data/out_valid/out_ready/out_last
//                       row-sum stream; out_last marks the job's final row
//   busy                job in progress (RUN or DRAIN)
//   done                one-cycle job completion pulse
//   overflow            sticky: a completed row was dropped on a full FIFO
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; FIFO is always empty here
// RUN   | accumulating chunks, pushing one sum per completed row
// DRAIN | all rows accounted for; waiting for the FIFO to empty
module mvm_row_accum #(
    parameter int IWIDTH     = 32,
    parameter int OWIDTH     = 32,
    parameter int MAX_CHUNKS = 16,
    parameter int MAX_ROWS   = 256,
    parameter int FIFO_DEPTH = 4,
    localparam int CW = $clog2(MAX_CHUNKS + 1),
    localparam int RW = $clog2(MAX_ROWS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CW-1:0]     num_chunks,
    input  logic [RW-1:0]     num_rows,
    input  logic [IWIDTH-1:0] in_result,
    input  logic              in_valid,
    output logic [OWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                    state;
    logic [CW-1:0]             cfg_chunks_m1;
    logic [RW-1:0]             cfg_rows_m1;
    logic [CW-1:0]             chunk_cnt;
    logic [RW-1:0]             row_cnt;
    logic signed [OWIDTH-1:0]  acc;
    logic                      done_q;

    logic [OWIDTH-1:0]         mem_data [FIFO_DEPTH];
    logic                      mem_last [FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             rd_ptr;
    logic [NW-1:0]             count;

    logic signed [OWIDTH-1:0]  ext;
    logic signed [OWIDTH-1:0]  sum;
    logic                      cfg_ok;
    logic                      chunk_end;
    logic                      row_final;
    logic                      fifo_full;
    logic                      pop;
    logic                      push_ok;
    logic                      drop;

    assign ext       = OWIDTH'(signed'(in_result));
    assign sum       = acc + ext;
    assign cfg_ok    = (num_chunks != '0) && (num_chunks <= CW'(MAX_CHUNKS)) &&
                       (num_rows != '0) && (num_rows <= RW'(MAX_ROWS));
    assign chunk_end = (state == RUN) && in_valid && (chunk_cnt == cfg_chunks_m1);
    assign row_final = (row_cnt == cfg_rows_m1);
    assign fifo_full = (count == NW'(FIFO_DEPTH));
    assign pop       = (count != '0) && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok   = chunk_end && (!fifo_full || pop);
    assign drop      = chunk_end && fifo_full && !pop;

    assign out_valid = (count != '0);
    assign out_data  = mem_data[rd_ptr];
    assign out_last  = out_valid && mem_last[rd_ptr];
    assign busy      = (state != IDLE);
    // Completion coincides with the handshake of the final entry, which
    // depends on out_ready in the same cycle; other completions are registered.
    assign done      = done_q || ((state == DRAIN) && pop && (count == NW'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cfg_chunks_m1 <= '0;
            cfg_rows_m1   <= '0;
            chunk_cnt     <= '0;
            row_cnt       <= '0;
            acc           <= '0;
            done_q        <= 1'b0;
            overflow      <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_last[i] <= 1'b0;
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            state         <= RUN;
                            cfg_chunks_m1 <= num_chunks - CW'(1);
                            cfg_rows_m1   <= num_rows - RW'(1);
                            overflow      <= 1'b0;
                            acc           <= '0;
                            chunk_cnt     <= '0;
                            row_cnt       <= '0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        if (chunk_end) begin
                            acc       <= '0;
                            chunk_cnt <= '0;
                            row_cnt   <= row_cnt + RW'(1);
                            if (drop)
                                overflow <= 1'b1;
                            if (row_final)
                                state <= DRAIN;
                        end else begin
                            acc       <= sum;
                            chunk_cnt <= chunk_cnt + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (pop && (count == NW'(1))) begin
                        state <= IDLE;
                    end else if (count == '0) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (push_ok) begin
                mem_data[wr_ptr] <= sum;
                mem_last[wr_ptr] <= row_final;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);

            case ({push_ok, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_row_accum.sv
// Directed bench for mvm_row_accum. Inputs change 1 ns after each rising
// edge; outputs are sampled 3 ns after the edge, well before the next one.
module tb_mvm_row_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  num_chunks;
    logic [8:0]  num_rows;
    logic [31:0] in_result;
    logic        in_valid;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mvm_row_accum #(
        .IWIDTH(32), .OWIDTH(32), .MAX_CHUNKS(16), .MAX_ROWS(256), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_chunks(num_chunks),
        .num_rows(num_rows), .in_result(in_result), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done), .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, then advance to the sampling point.
    task automatic cyc(input bit st, input bit v, input int d, input bit rdy);
        @(posedge clk);
        #1;
        start     = st;
        in_valid  = v;
        in_result = d;
        out_ready = rdy;
        #2;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_chunks = '0; num_rows = '0;
        in_result = '0; in_valid = 1'b0; out_ready = 1'b0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;

        // Single-chunk job: 5, -7, 100.
        num_chunks = 5'd1; num_rows = 9'd3;
        cyc(1, 0, 0, 1);
        chk("t1_busy_pre", busy, 0);
        cyc(0, 1, 5, 1);
        chk("t1_busy", busy, 1);
        chk("t1_empty", out_valid, 0);
        cyc(0, 1, -7, 1);
        chk("t1_v0", out_valid, 1);
        chk("t1_d0", out_data, 32'd5);
        chk("t1_l0", out_last, 0);
        cyc(0, 1, 100, 1);
        chk("t1_d1", out_data, 32'hFFFF_FFF9);
        chk("t1_l1", out_last, 0);
        chk("t1_done_early", done, 0);
        cyc(0, 0, 0, 1);
        chk("t1_v2", out_valid, 1);
        chk("t1_d2", out_data, 32'd100);
        chk("t1_l2", out_last, 1);
        chk("t1_done", done, 1);
        cyc(0, 0, 0, 1);
        chk("t1_done_off", done, 0);
        chk("t1_busy_off", busy, 0);
        chk("t1_drained", out_valid, 0);
        chk("t1_ovf", overflow, 0);

        // Multi-chunk with idle gaps: rows {1,2,3,4} and {10,-20,30,-40}.
        num_chunks = 5'd4; num_rows = 9'd2;
        cyc(1, 0, 0, 1);
        begin
            int vals [8] = '{1, 2, 3, 4, 10, -20, 30, -40};
            int sums [2] = '{10, -20};
            for (int r = 0; r < 2; r++) begin
                for (int k = 0; k < 4; k++) begin
                    int gap = $urandom_range(0, 2);
                    for (int g = 0; g < gap; g++) begin
                        cyc(0, 0, 0, 1);
                        chk("t2_gap_nv", out_valid, 0);
                    end
                    cyc(0, 1, vals[r*4+k], 1);
                    chk("t2_in_nv", out_valid, 0);
                end
                cyc(0, 0, 0, 1);
                chk("t2_v", out_valid, 1);
                chk("t2_d", out_data, sums[r]);
                chk("t2_l", out_last, (r == 1) ? 1 : 0);
                chk("t2_done", done, (r == 1) ? 1 : 0);
            end
        end
        cyc(0, 0, 0, 1);
        chk("t2_busy_off", busy, 0);

        // Backpressure and overflow: six single-chunk rows into a 4-deep FIFO.
        num_chunks = 5'd1; num_rows = 9'd6;
        cyc(1, 0, 0, 0);
        for (int j = 1; j <= 6; j++) begin
            cyc(0, 1, j, 0);
            if (j == 4) chk("t3_ovf_before", overflow, 0);
            if (j == 6) chk("t3_ovf_set", overflow, 1);
        end
        cyc(0, 0, 0, 0);
        chk("t3_hold_d_a", out_data, 32'd1);
        chk("t3_busy", busy, 1);
        cyc(0, 0, 0, 0);
        chk("t3_hold_d_b", out_data, 32'd1);
        chk("t3_hold_l", out_last, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 0, 0, 1);
            chk("t3_d", out_data, i);
            chk("t3_l", out_last, 0);
            chk("t3_done", done, (i == 4) ? 1 : 0);
        end
        cyc(0, 0, 0, 1);
        chk("t3_busy_off", busy, 0);
        chk("t3_empty", out_valid, 0);
        chk("t3_ovf_sticky", overflow, 1);

        // Full FIFO with simultaneous push and pop.
        num_chunks = 5'd1; num_rows = 9'd7;
        cyc(1, 0, 0, 0);
        for (int j = 1; j <= 4; j++) begin
            cyc(0, 1, j, 0);
            if (j == 1) chk("t4_ovf_cleared", overflow, 0);
        end
        for (int j = 5; j <= 7; j++) begin
            cyc(0, 1, j, 1);
            chk("t4_pp_d", out_data, j - 4);
        end
        for (int i = 4; i <= 7; i++) begin
            cyc(0, 0, 0, 1);
            chk("t4_d", out_data, i);
            chk("t4_l", out_last, (i == 7) ? 1 : 0);
            chk("t4_done", done, (i == 7) ? 1 : 0);
        end
        cyc(0, 0, 0, 1);
        chk("t4_ovf", overflow, 0);
        chk("t4_busy_off", busy, 0);

        // Wrap and sign extension.
        num_chunks = 5'd2; num_rows = 9'd2;
        cyc(1, 0, 0, 1);
        cyc(0, 1, 32'h7FFF_FFFF, 1);
        cyc(0, 1, 1, 1);
        cyc(0, 1, -1, 1);
        chk("t5_wrap", out_data, 32'h8000_0000);
        chk("t5_wrap_v", out_valid, 1);
        cyc(0, 1, -1, 1);
        chk("t5_mid_nv", out_valid, 0);
        cyc(0, 0, 0, 1);
        chk("t5_neg", out_data, 32'hFFFF_FFFE);
        chk("t5_neg_l", out_last, 1);
        chk("t5_done", done, 1);
        cyc(0, 0, 0, 1);

        // Reset in the middle of a job with rows buffered.
        num_chunks = 5'd1; num_rows = 9'd3;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 2, 0);
        cyc(0, 0, 0, 0);
        chk("t6_pre_v", out_valid, 1);
        chk("t6_pre_busy", busy, 1);
        rst = 1'b1;
        cyc(0, 0, 0, 0);
        chk("t6_rst_v", out_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        rst = 1'b0;
        cyc(0, 0, 0, 0);
        chk("t6_rst_done2", done, 0);

        // Zero-row start: done pulse only.
        num_chunks = 5'd2; num_rows = 9'd0;
        cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("t7_done", done, 1);
        chk("t7_busy", busy, 0);
        chk("t7_nv", out_valid, 0);
        cyc(0, 0, 0, 1);
        chk("t7_done_off", done, 0);

        // Start while busy is ignored: a 2-chunk, 1-row job keeps its config.
        num_chunks = 5'd2; num_rows = 9'd1;
        cyc(1, 0, 0, 1);
        cyc(0, 1, 3, 1);
        num_chunks = 5'd1; num_rows = 9'd1;
        cyc(1, 0, 0, 1);
        chk("t8_nv_mid", out_valid, 0);
        cyc(0, 1, 4, 1);
        chk("t8_nv_4", out_valid, 0);
        cyc(0, 0, 0, 1);
        chk("t8_d", out_data, 32'd7);
        chk("t8_l", out_last, 1);
        chk("t8_done", done, 1);
        cyc(0, 0, 0, 1);
        chk("t8_busy_off", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
